// File: rtl/key_mode_pkg.sv
// Shared definitions for the front-panel key/mode path.
// - mode codes driven to the LED blinker
// - key bit positions within the 3-bit key vectors
// - next_mode(): step sequence of the NEXT key
package key_mode_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'h0;
  localparam mode_t MODE_FAST = 3'h1;
  localparam mode_t MODE_SLOW = 3'h2;
  localparam mode_t MODE_ON   = 3'h3;

  localparam int unsigned KEY_NEXT = 0;
  localparam int unsigned KEY_ON   = 1;
  localparam int unsigned KEY_FAST = 2;

  // Cycles fast -> slow -> on -> fast; any code outside that loop
  // (hold or unused values) enters it at fast.
  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    unique case (cur)
      MODE_FAST: nxt = MODE_SLOW;
      MODE_SLOW: nxt = MODE_ON;
      default:   nxt = MODE_FAST;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/key_mode_ctrl_if.sv
// Key/mode bundle between the panel pins and the LED blinker.
// - key_in     : raw active-low buttons [0]=NEXT [1]=ON [2]=FAST
// - key_pulse  : one-cycle debounced press pulses
// - mode       : mode code level to the blinker
// - mode_valid : one-cycle strobe when mode takes a commanded value
// master drives the keys and observes results; slave is the controller.
interface key_mode_ctrl_if;
  logic [2:0] key_in;
  logic [2:0] key_pulse;
  logic [2:0] mode;
  logic       mode_valid;

  modport master (
    output key_in,
    input  key_pulse,
    input  mode,
    input  mode_valid
  );

  modport slave (
    input  key_in,
    output key_pulse,
    output mode,
    output mode_valid
  );
endinterface

// File: rtl/key_debounce.sv
// Debouncer for one active-low push button.
// - clk, rstn : clock and synchronous active-low reset
// - key_n     : raw button level, asynchronous to clk
// - press     : one-cycle pulse the cycle after the debounced level falls
// A new level is accepted only after DEB_CYC consecutive cycles that
// differ from the current stable level; any return to the stable level
// clears the count.
module key_debounce #(
  parameter int unsigned DEB_CYC = 1_000_000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYC - 1);

  logic             sync1_q;
  logic             s_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = s_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q      <= 1'b1;
      s_q          <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= key_n;
      s_q          <= sync1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      stable_dly_q <= stable_q;
      // Falling edge of the accepted level, seen one cycle after it lands.
      press_q      <= stable_dly_q & ~stable_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Front-panel key controller: debounces NEXT/ON/FAST and drives the LED
// blinker mode code.
// - clk, rstn : clock and synchronous active-low reset
// - bus       : key_mode_ctrl_if slave (key_in, key_pulse, mode, mode_valid)
// One command is executed per cycle with priority ON > FAST > NEXT;
// lower-priority pulses in the same cycle are dropped.
module key_mode_ctrl
  import key_mode_pkg::*;
#(
  parameter int unsigned DEB_CYC = 1_000_000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic            clk,
  input  logic            rstn,
  key_mode_ctrl_if.slave  bus
);

  logic [2:0] pulse;
  mode_t      mode_q, mode_d;
  logic       valid_q, valid_d;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEB_CYC (DEB_CYC),
      .CNT_W   (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rstn  (rstn),
      .key_n (bus.key_in[i]),
      .press (pulse[i])
    );
  end

  always_comb begin
    mode_d  = mode_q;
    valid_d = 1'b0;
    if (pulse[KEY_ON]) begin
      mode_d  = MODE_ON;
      valid_d = 1'b1;
    end else if (pulse[KEY_FAST]) begin
      mode_d  = MODE_FAST;
      valid_d = 1'b1;
    end else if (pulse[KEY_NEXT]) begin
      mode_d  = next_mode(mode_q);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q  <= MODE_HOLD;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  assign bus.key_pulse  = pulse;
  assign bus.mode       = mode_q;
  assign bus.mode_valid = valid_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Bench for key_mode_ctrl with DEB_CYC=8, CNT_W=4.
module tb_key_mode_ctrl;

  localparam int unsigned DebCyc = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  key_mode_ctrl_if bus ();

  key_mode_ctrl #(
    .DEB_CYC (DebCyc),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0] val;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [2:0] keys;  // 1 = pressed; [0]=NEXT [1]=ON [2]=FAST
    logic [2:0] mode;
  } vec_t;

  exp_t pulse_sb[$];
  exp_t mode_sb[$];
  vec_t vecs[15];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every pulse and every strobe must match a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.key_pulse != 3'b000) begin
      total++;
      if (pulse_sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d, want no pulse", bus.key_pulse, cyc);
      end else begin
        e = pulse_sb.pop_front();
        if (bus.key_pulse !== e.val || cyc != e.cyc) begin
          bad++;
          $display("FAIL key_pulse: got %b at cycle %0d, want %b at cycle %0d",
                   bus.key_pulse, cyc, e.val, e.cyc);
        end
      end
    end
    if (bus.mode_valid) begin
      total++;
      if (mode_sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got mode %0d at cycle %0d, want no strobe", bus.mode, cyc);
      end else begin
        e = mode_sb.pop_front();
        if (bus.mode !== e.val || cyc != e.cyc) begin
          bad++;
          $display("FAIL mode: got %0d at cycle %0d, want %0d at cycle %0d",
                   bus.mode, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Press keys for hold cycles from the next edge t; a counted press gives
  // key_pulse at t+10 and the mode strobe at t+11.
  task automatic press(input logic [2:0] keys, input int hold, input logic [2:0] exp_mode);
    int t;
    exp_t e;
    bus.key_in = ~keys;
    t = cyc + 1;
    e.val = keys;     e.cyc = t + DebCyc + 2; pulse_sb.push_back(e);
    e.val = exp_mode; e.cyc = t + DebCyc + 3; mode_sb.push_back(e);
    wait_cyc(hold);
    bus.key_in = 3'b111;
    wait_cyc(14);
  endtask

  initial begin
    vecs[0]  = '{3'b001, 3'd1};
    vecs[1]  = '{3'b001, 3'd2};
    vecs[2]  = '{3'b001, 3'd3};
    vecs[3]  = '{3'b001, 3'd1};
    vecs[4]  = '{3'b110, 3'd3};  // ON + FAST together: ON wins
    vecs[5]  = '{3'b100, 3'd1};
    vecs[6]  = '{3'b010, 3'd3};
    vecs[7]  = '{3'b010, 3'd3};  // re-command while already on
    vecs[8]  = '{3'b010, 3'd3};
    vecs[9]  = '{3'b001, 3'd1};
    vecs[10] = '{3'b101, 3'd1};  // FAST beats NEXT (NEXT would give 2)
    vecs[11] = '{3'b011, 3'd3};  // ON beats NEXT
    vecs[12] = '{3'b111, 3'd3};
    vecs[13] = '{3'b001, 3'd1};
    vecs[14] = '{3'b001, 3'd2};

    // Reset with keys released.
    rstn = 1'b0;
    bus.key_in = 3'b111;
    wait_cyc(3);
    check("reset_mode", {4'd0, bus.mode}, 7'd0);
    check("reset_valid", {6'd0, bus.mode_valid}, 7'd0);
    check("reset_pulse", {4'd0, bus.key_pulse}, 7'd0);
    rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      wait_cyc(1);
      check("idle_outputs", {bus.key_pulse, bus.mode, bus.mode_valid}, 7'd0);
    end

    // Table-driven clean presses.
    for (int i = 0; i < 15; i++) begin
      press(vecs[i].keys, 12, vecs[i].mode);
    end

    // Bounce: 5 low / 2 high / 5 low never completes a count.
    bus.key_in = 3'b110; wait_cyc(5);
    bus.key_in = 3'b111; wait_cyc(2);
    bus.key_in = 3'b110; wait_cyc(5);
    bus.key_in = 3'b111; wait_cyc(20);
    check("bounce_mode", {4'd0, bus.mode}, 7'd2);
    // Exactly DEB_CYC low cycles is enough for one press.
    press(3'b001, DebCyc, 3'd3);
    wait_cyc(6);

    // Reset mid-count with key released: partial count is lost.
    bus.key_in = 3'b110; wait_cyc(5);
    rstn = 1'b0; bus.key_in = 3'b111; wait_cyc(1);
    rstn = 1'b1; wait_cyc(20);
    check("midreset_mode", {4'd0, bus.mode}, 7'd0);

    // Key held across reset release: press reported from the release edge.
    bus.key_in = 3'b110; wait_cyc(5);
    rstn = 1'b0; wait_cyc(1);
    rstn = 1'b1;
    press(3'b001, 14, 3'd1);
    wait_cyc(6);

    check("pulse_sb_drained", 7'(pulse_sb.size()), 7'd0);
    check("mode_sb_drained", 7'(mode_sb.size()), 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
